// File: rtl/store_merge_ctrl_pkg.sv
// Shared definitions for the dcache store-merge controller: line geometry,
// store size codes and the sequencing FSM states.
package store_merge_ctrl_pkg;

    // The merge unit is built for 64-byte lines only.
    localparam int OFFSET_LEN = 6;
    localparam int LINE_W     = 1 << (OFFSET_LEN + 3);

    // Store size codes as carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_NOP  = 2'd3;

    // Read-modify-write sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_MERGE = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/store_merge_ctrl_insert_data.sv
// Line merge unit: overlays a byte, half-word or word onto a 512-bit line.
// Low offset bits below the access size are ignored (no alignment trap);
// with no write strobe set the line passes through unchanged.
module insert_data
    import store_merge_ctrl_pkg::*;
(
    input  logic [LINE_W-1:0]     origin_i,
    input  logic [OFFSET_LEN-1:0] offset_i,
    input  logic [31:0]           data_i,
    input  logic                  byte_write_i,
    input  logic                  half_word_write_i,
    input  logic                  word_write_i,
    output logic [LINE_W-1:0]     result_o
);

    // Replace the addressed lane of the line with the right-aligned store data.
    always_comb begin
        result_o = origin_i;
        if (word_write_i) begin
            result_o[{offset_i[5:2], 5'b0} +: 32] = data_i;
        end else if (half_word_write_i) begin
            result_o[{offset_i[5:1], 4'b0} +: 16] = data_i[15:0];
        end else if (byte_write_i) begin
            result_o[{offset_i, 3'b0} +: 8] = data_i[7:0];
        end
    end

endmodule

// File: rtl/store_merge_ctrl.sv
// Store merge controller: queues store hits, performs a read-modify-write of
// the target dcache line and coalesces consecutive stores to the same line
// into a single write-back. Also flags loads that target a line with a
// pending store.
//
// Handshake: a store is accepted on any rising edge where req_valid and
// req_ready are both high; req_ready depends only on queue occupancy, so it
// never reflects a pop happening in the same cycle.
module store_merge_ctrl
    import store_merge_ctrl_pkg::*;
#(
    parameter int Offset_len = 6,
    parameter int Index_len  = 6,
    parameter int Depth      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_data,
    input  logic [1:0]           req_size,
    output logic                 ram_ren,
    output logic [Index_len-1:0] ram_raddr,
    input  logic [LINE_W-1:0]    ram_rdata,
    output logic                 ram_wen,
    output logic [Index_len-1:0] ram_waddr,
    output logic [LINE_W-1:0]    ram_wdata,
    output logic                 dirty_set,
    input  logic [Index_len-1:0] ld_idx,
    output logic                 ld_conflict,
    output logic                 idle,
    output logic [1:0]           dbg_state
);

    localparam int PTR_W = $clog2(Depth);

    // Store queue storage (contents need no reset; occupancy is tracked by count_q).
    logic [Index_len-1:0]  q_idx_q  [Depth];
    logic [Offset_len-1:0] q_off_q  [Depth];
    logic [31:0]           q_data_q [Depth];
    logic [1:0]            q_size_q [Depth];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push, pop, q_empty, q_full;

    logic [Index_len-1:0]  head_idx;
    logic [Offset_len-1:0] head_off;
    logic [31:0]           head_data;
    logic [1:0]            head_size;

    state_e               state_q, state_d;
    logic [Index_len-1:0] line_idx_q, line_idx_d;
    logic [LINE_W-1:0]    line_buf_q, line_buf_d;

    logic [LINE_W-1:0] merge_origin, merged;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:Offset_len+Index_len];

    assign q_empty   = (count_q == '0);
    assign q_full    = (count_q == (PTR_W+1)'(Depth));
    assign req_ready = !q_full;
    assign push      = req_valid && req_ready;

    assign head_idx  = q_idx_q[rd_ptr_q];
    assign head_off  = q_off_q[rd_ptr_q];
    assign head_data = q_data_q[rd_ptr_q];
    assign head_size = q_size_q[rd_ptr_q];

    // Capture an accepted store into the tail slot.
    always_ff @(posedge clk) begin
        if (push) begin
            q_idx_q[wr_ptr_q]  <= req_addr[Offset_len+Index_len-1:Offset_len];
            q_off_q[wr_ptr_q]  <= req_addr[Offset_len-1:0];
            q_data_q[wr_ptr_q] <= req_data;
            q_size_q[wr_ptr_q] <= req_size;
        end
    end

    // Queue pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // The first store of a line merges into the fresh RAM data; later
    // coalesced stores merge into the line buffer.
    assign merge_origin = (state_q == ST_READ) ? ram_rdata : line_buf_q;

    insert_data u_insert_data (
        .origin_i          (merge_origin),
        .offset_i          (head_off),
        .data_i            (head_data),
        .byte_write_i      (head_size == SZ_BYTE),
        .half_word_write_i (head_size == SZ_HALF),
        .word_write_i      (head_size == SZ_WORD),
        .result_o          (merged)
    );

    // Read-modify-write sequencing and coalescing decisions.
    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        line_buf_d = line_buf_q;
        pop        = 1'b0;
        ram_ren    = 1'b0;
        ram_raddr  = '0;
        ram_wen    = 1'b0;
        dirty_set  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    ram_ren    = 1'b1;
                    ram_raddr  = head_idx;
                    line_idx_d = head_idx;
                    state_d    = ST_READ;
                end
            end
            ST_READ: begin
                // The head is still the store that started this line.
                line_buf_d = merged;
                pop        = 1'b1;
                state_d    = ST_MERGE;
            end
            ST_MERGE: begin
                if (!q_empty && (head_idx == line_idx_q)) begin
                    line_buf_d = merged;
                    pop        = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_wen   = 1'b1;
                dirty_set = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and line-buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            line_idx_q <= '0;
            line_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            line_buf_q <= line_buf_d;
        end
    end

    assign ram_waddr = line_idx_q;
    assign ram_wdata = line_buf_q;
    assign idle      = q_empty && (state_q == ST_IDLE);
    assign dbg_state = state_q;

    // Load conflict: any queued store or the line being built hits ld_idx.
    always_comb begin
        logic [PTR_W-1:0] rel;
        rel         = '0;
        ld_conflict = (state_q != ST_IDLE) && (line_idx_q == ld_idx);
        for (int i = 0; i < Depth; i++) begin
            rel = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, rel} < count_q) && (q_idx_q[i] == ld_idx)) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Directed bench for store_merge_ctrl with a behavioural line RAM and a
// write-back scoreboard of expected {index, line} pairs.
module tb_store_merge_ctrl;
    import store_merge_ctrl_pkg::*;

    localparam int IW   = 6;
    localparam int SB_W = IW + 512;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [31:0]    req_addr;
    logic [31:0]    req_data;
    logic [1:0]     req_size;
    logic           ram_ren;
    logic [IW-1:0]  ram_raddr;
    logic [511:0]   ram_rdata;
    logic           ram_wen;
    logic [IW-1:0]  ram_waddr;
    logic [511:0]   ram_wdata;
    logic           dirty_set;
    logic [IW-1:0]  ld_idx;
    logic           ld_conflict;
    logic           idle;
    logic [1:0]     dbg_state;

    logic [511:0]    mem [64];
    logic [SB_W-1:0] exp_q [$];
    logic [SB_W-1:0] mon_e;
    int              n_tests = 0;
    int              n_fail  = 0;
    int              wen_cnt = 0;

    store_merge_ctrl #(.Offset_len(6), .Index_len(IW), .Depth(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_size    (req_size),
        .ram_ren     (ram_ren),
        .ram_raddr   (ram_raddr),
        .ram_rdata   (ram_rdata),
        .ram_wen     (ram_wen),
        .ram_waddr   (ram_waddr),
        .ram_wdata   (ram_wdata),
        .dirty_set   (dirty_set),
        .ld_idx      (ld_idx),
        .ld_conflict (ld_conflict),
        .idle        (idle),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Line RAM with one-cycle read latency
    always @(posedge clk) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
    end

    // Write-back scoreboard
    always @(negedge clk) begin
        if (ram_wen || dirty_set) begin
            n_tests++;
            wen_cnt++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL wr_unexpected observed idx=%0d wen=%b dirty=%b expected no write",
                       ram_waddr, ram_wen, dirty_set);
            end else begin
                mon_e = exp_q.pop_front();
                assert ({ram_waddr, ram_wdata} === mon_e && ram_wen === 1'b1 && dirty_set === 1'b1)
                else begin
                    n_fail++;
                    $error("FAIL wr_line observed idx=%0d wen=%b dirty=%b data=%0h expected idx=%0d data=%0h",
                           ram_waddr, ram_wen, dirty_set, ram_wdata, mon_e[SB_W-1:512], mon_e[511:0]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] want);
        n_tests++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] mk_addr(input int idx, input int off);
        return 32'(idx * 64 + off);
    endfunction

    // Present one store for one edge (queue known to have room).
    task automatic send(input int idx, input int off, input logic [31:0] data, input logic [1:0] size);
        req_valid = 1'b1;
        req_addr  = mk_addr(idx, off);
        req_data  = data;
        req_size  = size;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for the controller to drain and all writes to be seen.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(idle === 1'b1 && exp_q.size() == 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        assert (idle === 1'b1 && exp_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL %s_drain observed idle=%b pending=%0d expected idle=1 pending=0",
                   tag, idle, exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Directed sequence
    initial begin
        logic [511:0] line_a, line_b;
        int           sent, cyc;
        int           acc_edge [6];
        logic         ready_hist [40];
        logic [1:0]   state_hist [40];
        logic         was_ready;

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; ld_idx = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", req_ready, 1);
        chk("rst_ren", ram_ren, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_dirty", dirty_set, 0);
        chk("rst_raddr", ram_raddr, 0);
        chk("rst_waddr", ram_waddr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_conflict", ld_conflict, 0);
        chk("rst_idle", idle, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single word store, latency profile
        line_a = '0;
        line_a[319:288] = 32'hDEADBEEF;
        exp_q.push_back({6'd3, line_a});
        send(3, 'h24, 32'hDEADBEEF, SZ_WORD);
        chk("t1_ren", ram_ren, 1);
        chk("t1_raddr", ram_raddr, 3);
        chk("t1_idle", idle, 0);
        @(negedge clk);
        chk("t1_read", dbg_state, ST_READ);
        @(negedge clk);
        chk("t1_merge", dbg_state, ST_MERGE);
        @(negedge clk);
        chk("t1_wen", ram_wen, 1);
        chk("t1_dirty", dirty_set, 1);
        chk("t1_waddr", ram_waddr, 3);
        wait_idle("t1");
        chk("t1_mem", mem[3], line_a);

        // Byte then half-word to the same line coalesce into one write
        mem[4] = {64{8'h5A}};
        line_a = {64{8'h5A}};
        line_a[511:504] = 8'hAA;
        line_a[31:16]   = 16'h1234;
        exp_q.push_back({6'd4, line_a});
        wen_cnt = 0;
        send(4, 'h3F, 32'h123456AA, SZ_BYTE);
        send(4, 'h02, 32'hFFFF1234, SZ_HALF);
        wait_idle("t2");
        chk("t2_wen_count", wen_cnt, 1);
        chk("t2_mem", mem[4], line_a);

        // Different lines: two sequences, no leakage; word at unaligned offset 3
        mem[5] = {64{8'h11}};
        mem[6] = {64{8'h22}};
        line_a = {64{8'h11}};
        line_a[31:0] = 32'hCAFEF00D;
        line_b = {64{8'h22}};
        line_b[135:128] = 8'h77;
        exp_q.push_back({6'd5, line_a});
        exp_q.push_back({6'd6, line_b});
        wen_cnt = 0;
        send(5, 'h03, 32'hCAFEF00D, SZ_WORD);
        send(6, 'h10, 32'h00000077, SZ_BYTE);
        chk("t3_read", dbg_state, ST_READ);
        @(negedge clk);
        chk("t3_merge", dbg_state, ST_MERGE);
        @(negedge clk);
        chk("t3_wen_a", ram_wen, 1);
        chk("t3_waddr_a", ram_waddr, 5);
        @(negedge clk);
        chk("t3_ren_b", ram_ren, 1);
        chk("t3_raddr_b", ram_raddr, 6);
        wait_idle("t3");
        chk("t3_wen_count", wen_cnt, 2);
        chk("t3_mem_b", mem[6], line_b);

        // Fill the queue with distinct lines; no bypass when full
        for (int i = 0; i < 6; i++) begin
            line_a = '0;
            line_a[32*i +: 32] = 32'h1000 + 32'(i);
            exp_q.push_back({6'(10 + i), line_a});
            acc_edge[i] = -1;
        end
        sent = 0;
        cyc  = 0;
        while (sent < 6 && cyc < 40) begin
            req_valid = 1'b1;
            req_addr  = mk_addr(10 + sent, 4 * sent);
            req_data  = 32'h1000 + 32'(sent);
            req_size  = SZ_WORD;
            was_ready = req_ready;
            ready_hist[cyc] = req_ready;
            state_hist[cyc] = dbg_state;
            @(negedge clk);
            if (was_ready) begin
                acc_edge[sent] = cyc;
                sent++;
            end
            cyc++;
        end
        req_valid = 1'b0;
        chk("t4_sent", sent, 6);
        chk("t4_acc0", acc_edge[0], 0);
        chk("t4_acc3", acc_edge[3], 3);
        chk("t4_acc4", acc_edge[4], 4);
        chk("t4_acc5_held", acc_edge[5], 7);
        chk("t4_full_ready", ready_hist[5], 0);
        chk("t4_pop_state", state_hist[6], ST_READ);
        chk("t4_nobypass_ready", ready_hist[6], 0);
        wait_idle("t4");
        chk("t4_mem_last", mem[15], line_a);

        // Load conflict tracking, then a no-op store on a non-matching probe
        mem[9] = {64{8'h3C}};
        line_a = {64{8'h3C}};
        line_a[7:0] = 8'h01;
        exp_q.push_back({6'd9, line_a});
        ld_idx = 6'd9;
        @(negedge clk);
        chk("t5_conflict_empty", ld_conflict, 0);
        send(9, 'h00, 32'h00000001, SZ_BYTE);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("t5_conflict_c%0d", c), ld_conflict, (c <= 4) ? 1 : 0);
            @(negedge clk);
        end
        wait_idle("t5a");
        exp_q.push_back({6'd9, line_a});
        ld_idx = 6'd8;
        send(9, 'h11, 32'hFFFFFFFF, SZ_NOP);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("t5_noconflict_c%0d", c), ld_conflict, 0);
            @(negedge clk);
        end
        wait_idle("t5b");
        chk("t5_mem_nop", mem[9], line_a);

        // Reset during MERGE discards the line
        mem[20] = {64{8'hEE}};
        wen_cnt = 0;
        send(20, 'h00, 32'h000000AB, SZ_BYTE);
        send(20, 'h01, 32'h000000CD, SZ_BYTE);
        @(negedge clk);
        chk("t6_in_merge", dbg_state, ST_MERGE);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_wen", ram_wen, 0);
        chk("t6_idle", idle, 1);
        chk("t6_ready", req_ready, 1);
        chk("t6_wdata", ram_wdata, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_no_write", wen_cnt, 0);
        chk("t6_mem", mem[20], {64{8'hEE}});

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
